// File: rtl/game_round_controller.sv
// Billiard game-flow FSM: stage sequencing, lives, per-stage BCD countdown and saturating BCD score.
// Outputs registered from next state (1 cycle after the deciding inputs); no backpressure, inputs sampled every cycle.
module game_round_controller #(
    parameter int NUM_BALLS   = 2,
    parameter int NUM_STAGES  = 4,
    parameter int LIVES       = 3,
    parameter int STAGE_TIME  = 60,
    parameter int HOLD_SEC    = 2,
    parameter int TICK_CYCLES = 50_000_000
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               start,
    input  logic [NUM_BALLS:0] balls_in_game,
    input  logic [NUM_BALLS:0] ballhole_coll,
    output logic               stage_load,
    output logic               winPulse,
    output logic               losePulse,
    output logic               scoredPulse,
    output logic               gameOverPulse,
    output logic [3:0]         stage_num,
    output logic [2:0]         lives_left,
    output logic [3:0]         scoreL,
    output logic [3:0]         scoreH,
    output logic [3:0]         timeL,
    output logic [3:0]         timeH,
    output logic               game_won
);

    localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int HW = (HOLD_SEC > 1) ? $clog2(HOLD_SEC) : 1;
    localparam int PW = $clog2(NUM_BALLS + 1);
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_SEC - 1);
    localparam logic [3:0]    TIME_INITH = 4'(STAGE_TIME / 10);
    localparam logic [3:0]    TIME_INITL = 4'(STAGE_TIME % 10);
    localparam logic [2:0]    LIVES_INIT = 3'(LIVES);
    localparam logic [3:0]    LAST_STAGE = 4'(NUM_STAGES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_PLAY,
        S_WIN,
        S_LOSE,
        S_OVER
    } state_t;

    state_t          state;
    state_t          nextState;
    logic [TW-1:0]   tickCnt;
    logic [HW-1:0]   holdCnt;
    logic [PW-1:0]   potCount;
    logic [3:0]      scoreNextH;
    logic [3:0]      scoreNextL;
    int              scoreSum;
    logic            tick;
    logic            holdDone;
    logic            timeZero;
    logic            tableClear;
    logic            inHold;

    assign tick       = (tickCnt == TICK_LAST);
    assign inHold     = (state == S_WIN) || (state == S_LOSE);
    assign holdDone   = inHold && tick && (holdCnt == HOLD_LAST);
    assign timeZero   = (timeH == 4'd0) && (timeL == 4'd0);
    assign tableClear = (balls_in_game[NUM_BALLS:1] == '0) && balls_in_game[0];

    // Several object balls can drop in the same cycle; they count as one scoring event.
    always_comb begin
        potCount = '0;
        for (int i = 1; i <= NUM_BALLS; i++) begin
            potCount = potCount + PW'(ballhole_coll[i]);
        end
        scoreSum = int'(scoreH) * 10 + int'(scoreL) + int'(potCount);
        if (scoreSum > 99) begin
            scoreSum = 99;
        end
        scoreNextH = 4'(scoreSum / 10);
        scoreNextL = 4'(scoreSum % 10);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state <= S_IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            S_IDLE, S_OVER: begin
                if (start) nextState = S_LOAD;
            end
            S_LOAD: nextState = S_PLAY;
            S_PLAY: begin
                // A potted cue ball beats a cleared table in the same cycle.
                if (ballhole_coll[0])  nextState = S_LOSE;
                else if (timeZero)     nextState = S_LOSE;
                else if (tableClear)   nextState = S_WIN;
            end
            S_WIN: begin
                if (holdDone) nextState = (stage_num < LAST_STAGE) ? S_LOAD : S_OVER;
            end
            S_LOSE: begin
                if (holdDone) nextState = (lives_left != 3'd0) ? S_LOAD : S_OVER;
            end
            default: nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            stage_load    <= 1'b0;
            winPulse      <= 1'b0;
            losePulse     <= 1'b0;
            scoredPulse   <= 1'b0;
            gameOverPulse <= 1'b0;
            stage_num     <= 4'd0;
            lives_left    <= LIVES_INIT;
            scoreH        <= 4'd0;
            scoreL        <= 4'd0;
            timeH         <= TIME_INITH;
            timeL         <= TIME_INITL;
            game_won      <= 1'b0;
            tickCnt       <= '0;
            holdCnt       <= '0;
        end else begin
            stage_load    <= (nextState == S_LOAD);
            winPulse      <= (nextState == S_WIN);
            losePulse     <= (nextState == S_LOSE);
            gameOverPulse <= (nextState == S_OVER) && (state != S_OVER);
            scoredPulse   <= (state == S_PLAY) && (potCount != '0);

            if ((state == S_IDLE || state == S_OVER) && start) begin
                stage_num  <= 4'd1;
                lives_left <= LIVES_INIT;
                scoreH     <= 4'd0;
                scoreL     <= 4'd0;
                game_won   <= 1'b0;
            end

            if (state == S_PLAY && potCount != '0) begin
                scoreH <= scoreNextH;
                scoreL <= scoreNextL;
            end

            if (state == S_PLAY && nextState == S_LOSE) begin
                lives_left <= (lives_left == 3'd0) ? 3'd0 : lives_left - 3'd1;
            end

            if (state == S_WIN && holdDone) begin
                if (stage_num < LAST_STAGE) begin
                    stage_num <= stage_num + 4'd1;
                end else begin
                    game_won <= 1'b1;
                end
            end

            // The second counter restarts with each stage and keeps running through the hold states.
            if (nextState == S_LOAD) begin
                tickCnt <= '0;
            end else if (state == S_PLAY || inHold) begin
                tickCnt <= tick ? '0 : tickCnt + TW'(1);
            end

            if (nextState == S_LOAD) begin
                timeH <= TIME_INITH;
                timeL <= TIME_INITL;
            end else if (state == S_PLAY && tick && !timeZero) begin
                if (timeL == 4'd0) begin
                    timeH <= timeH - 4'd1;
                    timeL <= 4'd9;
                end else begin
                    timeL <= timeL - 4'd1;
                end
            end

            if (nextState != state) begin
                holdCnt <= '0;
            end else if (inHold && tick) begin
                holdCnt <= holdCnt + HW'(1);
            end
        end
    end

endmodule
